// File: rtl/data_memory_param.sv
// -----------------------------------------------------------------------------
// data_memory_param
//   Parameterised data memory for the pipelined MIPS matrix-multiplier datapath.
//   A CPU port offers byte-enabled stores and registered single-cycle loads with
//   out-of-range detection. A sequencer can zero the array after reset. A
//   handshaked dump engine streams a region of words to a monitor.
//
// Ports
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     CPU word address
//   write_data  CPU store data
//   byte_en     per-byte store enable, bit i covers bits [8i+7:8i]
//   mem_read    CPU load request
//   mem_write   CPU store request
//   read_data   registered load data, held until the next load
//   read_valid  one-cycle pulse, read_data is valid
//   addr_err    one-cycle pulse, out-of-range access or dump truncation
//   busy        high while the array is being cleared (CPU port ignored)
//   dump_start  start-dump pulse, accepted only when idle
//   dump_base   first word to dump
//   dump_len    number of words to dump
//   dump_data   streamed word
//   dump_valid  dump_data is valid
//   dump_ready  consumer accepts dump_data
//   dump_done   one-cycle pulse after the last word has been accepted
// -----------------------------------------------------------------------------
module data_memory_param #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DEPTH          = 30,
  parameter int unsigned RD_MODE        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [DATA_W/8-1:0]   byte_en,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_W-1:0]     read_data,
  output logic                  read_valid,
  output logic                  addr_err,
  output logic                  busy,
  input  logic                  dump_start,
  input  logic [ADDR_W-1:0]     dump_base,
  input  logic [ADDR_W:0]       dump_len,
  output logic [DATA_W-1:0]     dump_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic                  dump_done
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_DUMP} state_e;

  // NOTE: the storage array has no reset; clearing it is the job of the CLEAR
  // sequencer, which keeps the array mappable onto plain RAM.
  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [DATA_W-1:0] read_data_q;
  logic              read_valid_q;
  logic              addr_err_q;
  logic [ADDR_W-1:0] dump_addr_q;
  logic [CNT_W-1:0]  dump_left_q;
  logic [DATA_W-1:0] dump_data_q;
  logic              dump_valid_q;
  logic              dump_done_q;

  // ---------------------------------------------------------------------------
  // CPU port decode
  // ---------------------------------------------------------------------------
  logic              in_range;
  logic              cpu_we;
  logic              cpu_err;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] merged_d;
  logic [DATA_W-1:0] rd_word;

  assign in_range = ({1'b0, address} < DEPTH_C);
  assign cpu_we   = !busy_q && mem_write && in_range && (|byte_en);
  // Read+write out of range still counts as one error, hence the OR.
  assign cpu_err  = !busy_q && (mem_read || mem_write) && !in_range;
  assign cur_word = mem_q[address];

  // NOTE: every always_comb output gets a full default before any conditional
  // override, so no path can leave it unassigned and infer a latch.
  always_comb begin
    merged_d = cur_word;
    for (int i = 0; i < NB; i++) begin
      if (byte_en[i]) merged_d[8*i +: 8] = write_data[8*i +: 8];
    end
  end

  always_comb begin
    rd_word = '0;
    if (in_range) begin
      rd_word = ((RD_MODE == 1) && cpu_we) ? merged_d : cur_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Dump request decode: clip the requested window to the array.
  // ---------------------------------------------------------------------------
  logic [CNT_W:0]    dump_end;
  logic              base_ok;
  logic              overrun;
  logic [CNT_W-1:0]  avail;
  logic [CNT_W-1:0]  eff_len_d;
  logic              dump_go;
  logic              trunc_err;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_word;

  assign dump_end  = {2'b00, dump_base} + {1'b0, dump_len};
  assign base_ok   = ({1'b0, dump_base} < DEPTH_C);
  assign overrun   = (dump_end > {1'b0, DEPTH_C});
  assign avail     = DEPTH_C - {1'b0, dump_base};
  assign eff_len_d = !base_ok ? '0 : (overrun ? avail : dump_len);
  assign dump_go   = (state_q == S_IDLE) && dump_start;
  assign trunc_err = dump_go && overrun;

  // The first word is fetched at the accepting edge, later words at each
  // handshake. A CPU store landing on that same edge is forwarded so the dump
  // never misses a store to a word it has not yet presented.
  assign fetch_addr = (state_q == S_IDLE) ? dump_base : dump_addr_q + 1'b1;
  assign fetch_word = (cpu_we && (address == fetch_addr)) ? merged_d
                                                          : mem_q[fetch_addr];

  // ---------------------------------------------------------------------------
  // Storage write port: the clear sequencer owns it while busy.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (state_q == S_CLEAR) begin
      mem_q[clr_addr_q] <= '0;
    end else if (cpu_we) begin
      mem_q[address] <= merged_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      busy_q       <= (CLEAR_ON_RESET != 0);
      clr_addr_q   <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      dump_addr_q  <= '0;
      dump_left_q  <= '0;
      dump_data_q  <= '0;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
    end else begin
      read_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
      addr_err_q   <= cpu_err || trunc_err;

      if (!busy_q && mem_read) begin
        read_valid_q <= 1'b1;
        read_data_q  <= rd_word;
      end

      case (state_q)
        S_CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == LAST_ADDR) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        S_IDLE: begin
          if (dump_start) begin
            if (eff_len_d == '0) begin
              dump_done_q <= 1'b1;
            end else begin
              state_q      <= S_DUMP;
              dump_addr_q  <= dump_base;
              dump_left_q  <= eff_len_d;
              dump_data_q  <= fetch_word;
              dump_valid_q <= 1'b1;
            end
          end
        end

        S_DUMP: begin
          if (dump_valid_q && dump_ready) begin
            if (dump_left_q == CNT_W'(1)) begin
              dump_valid_q <= 1'b0;
              dump_done_q  <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              dump_addr_q <= dump_addr_q + 1'b1;
              dump_left_q <= dump_left_q - 1'b1;
              dump_data_q <= fetch_word;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign addr_err   = addr_err_q;
  assign busy       = busy_q;
  assign dump_data  = dump_data_q;
  assign dump_valid = dump_valid_q;
  assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_data_memory_param.sv
// -----------------------------------------------------------------------------
// tb_data_memory_param
//   Self-checking bench for data_memory_param (DATA_W=32, ADDR_W=5, DEPTH=30).
//   Two instances share all inputs: dut (RD_MODE=0) and dut1 (RD_MODE=1).
//   A word-array model of the memory supplies the expected values.
// -----------------------------------------------------------------------------
module tb_data_memory_param;

  localparam int DEPTH = 30;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  address;
  logic [31:0] write_data;
  logic [3:0]  byte_en;
  logic        mem_read, mem_write;
  logic        dump_start, dump_ready;
  logic [4:0]  dump_base;
  logic [5:0]  dump_len;

  logic [31:0] rd0, rd1, dd0, dd1;
  logic        rv0, rv1, err0, err1, busy0, busy1, dv0, dv1, done0, done1;

  always #5 clock = ~clock;

  data_memory_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(30), .RD_MODE(0), .CLEAR_ON_RESET(1)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .write_data(write_data),
    .byte_en(byte_en), .mem_read(mem_read), .mem_write(mem_write),
    .read_data(rd0), .read_valid(rv0), .addr_err(err0), .busy(busy0),
    .dump_start(dump_start), .dump_base(dump_base), .dump_len(dump_len),
    .dump_data(dd0), .dump_valid(dv0), .dump_ready(dump_ready), .dump_done(done0)
  );

  data_memory_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(30), .RD_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .address(address), .write_data(write_data),
    .byte_en(byte_en), .mem_read(mem_read), .mem_write(mem_write),
    .read_data(rd1), .read_valid(rv1), .addr_err(err1), .busy(busy1),
    .dump_start(dump_start), .dump_base(dump_base), .dump_len(dump_len),
    .dump_data(dd1), .dump_valid(dv1), .dump_ready(dump_ready), .dump_done(done1)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] last0, last1;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [4:0] a,
                              input logic [31:0] d, input logic [3:0] be,
                              input logic [31:0] e0, input logic [31:0] e1, input logic ee);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d; v.be = be;
    v.exp0 = e0; v.exp1 = e1; v.exp_err = ee;
    return v;
  endfunction

  // One CPU cycle, checked against the model; returns what both DUTs showed.
  task automatic cpu_op(input logic rd, input logic wr, input logic [4:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] g0, output logic [31:0] g1, output logic ge);
    logic [31:0] old_w, new_w;
    logic        inr;
    inr   = (int'(a) < DEPTH);
    old_w = 32'd0;
    if (inr) old_w = model_mem[a];
    new_w = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) new_w[8*i +: 8] = d[8*i +: 8];
    mem_read = rd; mem_write = wr; address = a; write_data = d; byte_en = be;
    @(posedge clock); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    if (rd) begin
      last0 = inr ? old_w : 32'd0;
      last1 = inr ? (wr ? new_w : old_w) : 32'd0;
    end
    check($sformatf("rvalid0@%0d", a), rv0, rd);
    check($sformatf("rvalid1@%0d", a), rv1, rd);
    check($sformatf("rdata0@%0d", a), rd0, last0);
    check($sformatf("rdata1@%0d", a), rd1, last1);
    check($sformatf("addr_err@%0d", a), err0, (rd || wr) && !inr);
    if (wr && inr) model_mem[a] = new_w;
    g0 = rd0; g1 = rd1; ge = err0;
  endtask

  task automatic reset_and_clear();
    int n;
    bit seen_rv, seen_dump;
    reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    dump_start = 1'b0; dump_ready = 1'b0;
    @(negedge clock);
    check("rst_read_valid", rv0, 1'b0);
    check("rst_read_data", rd0, 32'd0);
    check("rst_addr_err", err0, 1'b0);
    check("rst_dump_data", dd0, 32'd0);
    check("rst_dump_valid", dv0, 1'b0);
    check("rst_dump_done", done0, 1'b0);
    check("rst_busy", busy0, 1'b1);
    reset_n = 1'b1;
    // Accesses and a dump request while clearing must all be ignored.
    mem_read = 1'b1; mem_write = 1'b1; address = 5'd3; write_data = 32'hFFFF_FFFF;
    byte_en = 4'hF; dump_start = 1'b1; dump_base = 5'd0; dump_len = 6'd3;
    n = 0; seen_rv = 0; seen_dump = 0;
    forever begin
      @(posedge clock); #1;
      dump_start = 1'b0;
      n++;
      if (rv0 || rv1 || err0) seen_rv = 1;
      if (dv0 || done0) seen_dump = 1;
      if (!busy0 || n >= 100) break;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    check("busy_cycles", n, DEPTH);
    check("no_cpu_during_clear", seen_rv, 1'b0);
    check("no_dump_during_clear", seen_dump, 1'b0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    last0 = 32'd0; last1 = 32'd0;
  endtask

  // Dump with a ready pattern (0: toggle 1,0,..  1: random  2: always ready).
  // Optionally injects one CPU store on the first streaming cycle.
  task automatic run_dump(input int base, input int len, input int mode,
                          input bit inj, input logic [4:0] inj_a, input logic [31:0] inj_d,
                          input string tag);
    int          eff, cyc, done_cnt, stab_err, extra_err;
    bit          exp_err, stall, rdy;
    logic [31:0] prev;
    logic [31:0] got[$];
    exp_err = (base + len > DEPTH);
    eff     = (base >= DEPTH) ? 0 : ((base + len > DEPTH) ? DEPTH - base : len);
    dump_base = 5'(base); dump_len = 6'(len); dump_start = 1'b1; dump_ready = 1'b0;
    @(posedge clock); #1;
    dump_start = 1'b0;
    check({tag, "_trunc_err"}, err0, exp_err);
    check({tag, "_first_valid"}, dv0, eff > 0);
    if (inj) begin
      mem_write = 1'b1; address = inj_a; write_data = inj_d; byte_en = 4'hF;
    end
    cyc = 0; done_cnt = 0; stab_err = 0; extra_err = 0; stall = 0; prev = 32'd0;
    while (cyc < 400) begin
      if (cyc > 0 && err0) extra_err++;
      if (done0) begin
        done_cnt++;
        check({tag, "_valid_at_done"}, dv0, 1'b0);
        break;
      end
      if (stall && (!dv0 || dd0 !== prev)) stab_err++;
      case (mode)
        0:       rdy = (cyc % 2 == 0);
        1:       rdy = 1'($urandom % 2);
        default: rdy = 1'b1;
      endcase
      dump_ready = rdy;
      if (dv0 && rdy) got.push_back(dd0);
      stall = dv0 && !rdy;
      prev  = dd0;
      @(posedge clock); #1;
      cyc++;
      if (inj && cyc == 1) begin
        mem_write = 1'b0;
        model_mem[inj_a] = inj_d;
      end
    end
    dump_ready = 1'b0;
    check({tag, "_done_seen"}, done_cnt, 1);
    @(posedge clock); #1;
    check({tag, "_done_single"}, done0, 1'b0);
    check({tag, "_err_single"}, extra_err, 0);
    check({tag, "_stable"}, stab_err, 0);
    check({tag, "_count"}, got.size(), eff);
    for (int i = 0; i < got.size() && i < eff; i++)
      check($sformatf("%s_word%0d", tag, i), got[i], model_mem[base + i]);
  endtask

  vec_t        vecs[19];
  logic [31:0] g0, g1;
  logic        ge;

  initial begin
    reset_n = 1'b0; address = '0; write_data = '0; byte_en = '0;
    mem_read = 1'b0; mem_write = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
    dump_base = '0; dump_len = '0; last0 = '0; last1 = '0;

    vecs[0]  = mk(0, 1, 5'd0,  32'd6, 4'hF, 32'd0, 32'd0, 0);
    vecs[1]  = mk(0, 1, 5'd1,  32'd2, 4'hF, 32'd0, 32'd0, 0);
    vecs[2]  = mk(0, 1, 5'd2,  32'd3, 4'hF, 32'd0, 32'd0, 0);
    vecs[3]  = mk(0, 1, 5'd3,  32'd5, 4'hF, 32'd0, 32'd0, 0);
    vecs[4]  = mk(0, 1, 5'd4,  32'd5, 4'hF, 32'd0, 32'd0, 0);
    vecs[5]  = mk(0, 1, 5'd5,  32'd4, 4'hF, 32'd0, 32'd0, 0);
    vecs[6]  = mk(0, 1, 5'd6,  32'd5, 4'hF, 32'd0, 32'd0, 0);
    vecs[7]  = mk(0, 1, 5'd7,  32'd6, 4'hF, 32'd0, 32'd0, 0);
    vecs[8]  = mk(0, 1, 5'd8,  32'd5, 4'hF, 32'd0, 32'd0, 0);
    vecs[9]  = mk(1, 0, 5'd4,  32'd0, 4'h0, 32'd5, 32'd5, 0);
    vecs[10] = mk(0, 1, 5'd4,  32'hAABBCCDD, 4'b0101, 32'd0, 32'd0, 0);
    vecs[11] = mk(1, 0, 5'd4,  32'd0, 4'h0, 32'h00BB00DD, 32'h00BB00DD, 0);
    vecs[12] = mk(0, 1, 5'd10, 32'd2, 4'hF, 32'd0, 32'd0, 0);
    vecs[13] = mk(1, 1, 5'd10, 32'd7, 4'hF, 32'd2, 32'd7, 0);
    vecs[14] = mk(1, 0, 5'd10, 32'd0, 4'h0, 32'd7, 32'd7, 0);
    vecs[15] = mk(1, 1, 5'd31, 32'hFFFFFFFF, 4'hF, 32'd0, 32'd0, 1);
    vecs[16] = mk(0, 0, 5'd0,  32'd0, 4'h0, 32'd0, 32'd0, 0);
    vecs[17] = mk(0, 1, 5'd5,  32'hFFFFFFFF, 4'h0, 32'd0, 32'd0, 0);
    vecs[18] = mk(1, 0, 5'd5,  32'd0, 4'h0, 32'd4, 32'd4, 0);

    // Clear after reset, then every word reads back zero.
    reset_and_clear();
    for (int a = 0; a < DEPTH; a++) cpu_op(1, 0, 5'(a), 32'd0, 4'h0, g0, g1, ge);

    // Directed vectors.
    for (int i = 0; i < 19; i++) begin
      cpu_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, g0, g1, ge);
      if (vecs[i].rd) begin
        check($sformatf("vec%0d_rd_mode0", i), g0, vecs[i].exp0);
        check($sformatf("vec%0d_rd_mode1", i), g1, vecs[i].exp1);
      end
      check($sformatf("vec%0d_err", i), ge, vecs[i].exp_err);
    end

    // Nothing changed by the out-of-range store.
    for (int a = 0; a < DEPTH; a++) cpu_op(1, 0, 5'(a), 32'd0, 4'h0, g0, g1, ge);

    // Dumps.
    for (int i = 0; i < 9; i++) cpu_op(0, 1, 5'(18 + i), 32'(i + 1), 4'hF, g0, g1, ge);
    run_dump(18, 9, 0, 0, 5'd0, 32'd0, "dump_18_9");
    run_dump(25, 9, 2, 0, 5'd0, 32'd0, "dump_trunc");
    run_dump(30, 3, 2, 0, 5'd0, 32'd0, "dump_base_oor");
    run_dump(3, 0, 2, 0, 5'd0, 32'd0, "dump_len0");
    run_dump(0, 6, 0, 1, 5'd5, 32'hCAFEF00D, "dump_inject");

    // Random CPU traffic.
    for (int i = 0; i < 300; i++)
      cpu_op(1'($urandom % 2), 1'($urandom % 2), 5'($urandom_range(0, 31)),
             $urandom, 4'($urandom % 16), g0, g1, ge);
    for (int i = 0; i < 4; i++)
      run_dump($urandom_range(0, 29), $urandom_range(0, 32), 1, 0, 5'd0, 32'd0,
               $sformatf("dump_rand%0d", i));
    for (int a = 0; a < DEPTH; a++) cpu_op(1, 0, 5'(a), 32'd0, 4'h0, g0, g1, ge);

    // Reset in the middle of a dump.
    dump_base = 5'd18; dump_len = 6'd9; dump_start = 1'b1; dump_ready = 1'b0;
    @(posedge clock); #1;
    dump_start = 1'b0;
    check("mid_dump_valid_before", dv0, 1'b1);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_dump_valid", dv0, 1'b0);
    check("mid_rst_dump_done", done0, 1'b0);
    check("mid_rst_busy", busy0, 1'b1);
    check("mid_rst_read_data", rd0, 32'd0);
    reset_and_clear();
    for (int a = 0; a < DEPTH; a++) cpu_op(1, 0, 5'(a), 32'd0, 4'h0, g0, g1, ge);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
